// File: rtl/keypad_entry_if.sv
// keypad_entry_if: bundles the keypad scanner bitmap, sample enable and the
// entry/display results. The scanner side uses the master modport, the entry
// logic uses the slave modport.
interface keypad_entry_if;
    logic        en;
    logic [9:0]  numbers;
    logic        asterisk;
    logic        hash;
    logic [15:0] hexx;
    logic [3:0]  mask;
    logic        full;
    logic [15:0] value;
    logic        valid;

    modport master (
        output en, numbers, asterisk, hash,
        input  hexx, mask, full, value, valid
    );

    modport slave (
        input  en, numbers, asterisk, hash,
        output hexx, mask, full, value, valid
    );
endinterface

// File: rtl/keypad_entry.sv
// keypad_entry: debounces the 12-key scanner bitmap, accepts single-key
// presses and assembles up to four BCD digits into an edit buffer that also
// feeds the 7-segment display. '#' commits the buffer as a one-cycle valid
// value; '*' clears the buffer.
// Build option: define KEYPAD_ENTRY_BACKSPACE_EN to turn '*' into a
// backspace that drops only the most recent digit.
//
// state | meaning
// IDLE  | no key accepted; waiting for a single-key pattern
// DEB   | candidate key latched; counting identical samples
// HELD  | key accepted and its action done; waiting for all keys up
// REL   | all keys up; counting release samples before re-arming
module keypad_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    keypad_entry_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEB  = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } state_t;

    // cnt already holds the samples seen, so the accepting edge is the one
    // where cnt has reached DEBOUNCE_CYCLES-1.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_t      state;
    logic [11:0] key;
    logic [7:0]  cnt;
    logic [15:0] hexx_r;
    logic [2:0]  count;
    logic [3:0]  mask_r;
    logic        full_r;
    logic [15:0] value_r;
    logic        valid_r;

    logic [11:0] k;
    logic        single;
    logic        none;

    // Lowest set bit position of the digit field; only used on one-hot keys.
    function automatic logic [3:0] digit_of(input logic [9:0] n);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (n[i]) d = 4'(i);
        end
        return d;
    endfunction

    // Thermometer mask for the number of digits held.
    function automatic logic [3:0] mask_of(input logic [2:0] c);
        logic [3:0] m;
        case (c)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Decode the raw bitmap into single-key / no-key qualifiers.
    always_comb begin
        k      = {bus.hash, bus.asterisk, bus.numbers};
        single = $onehot(k);
        none   = (k == 12'd0);
    end

    // Debounce FSM plus edit buffer; the key action fires on the accepting
    // DEB edge so every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key     <= 12'd0;
            cnt     <= 8'd0;
            hexx_r  <= 16'd0;
            count   <= 3'd0;
            mask_r  <= 4'd0;
            full_r  <= 1'b0;
            value_r <= 16'd0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (bus.en) begin
                case (state)
                    IDLE: begin
                        if (single) begin
                            key   <= k;
                            cnt   <= 8'd1;
                            state <= DEB;
                        end
                    end
                    DEB: begin
                        if (k != key) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 8'd1;
                            if (cnt == CNT_LAST) begin
                                state <= HELD;
                                if (key[11]) begin
                                    // Commit; an empty buffer yields no pulse.
                                    if (count != 3'd0) begin
                                        value_r <= hexx_r;
                                        valid_r <= 1'b1;
                                        hexx_r  <= 16'd0;
                                        count   <= 3'd0;
                                        mask_r  <= 4'b0000;
                                        full_r  <= 1'b0;
                                    end
                                end else if (key[10]) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
                                    if (count != 3'd0) begin
                                        hexx_r <= {4'h0, hexx_r[15:4]};
                                        count  <= count - 3'd1;
                                        mask_r <= mask_of(count - 3'd1);
                                        full_r <= 1'b0;
                                    end
`else
                                    hexx_r <= 16'd0;
                                    count  <= 3'd0;
                                    mask_r <= 4'b0000;
                                    full_r <= 1'b0;
`endif
                                end else if (count != 3'd4) begin
                                    hexx_r <= {hexx_r[11:0], digit_of(key[9:0])};
                                    count  <= count + 3'd1;
                                    mask_r <= mask_of(count + 3'd1);
                                    full_r <= (count == 3'd3);
                                end
                            end
                        end
                    end
                    HELD: begin
                        if (none) begin
                            cnt   <= 8'd1;
                            state <= REL;
                        end
                    end
                    REL: begin
                        if (!none) begin
                            state <= HELD;
                        end else begin
                            cnt <= cnt + 8'd1;
                            if (cnt == CNT_LAST) begin
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.hexx  = hexx_r;
    assign bus.mask  = mask_r;
    assign bus.full  = full_r;
    assign bus.value = value_r;
    assign bus.valid = valid_r;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: table of key presses with expected buffer state, plus
// hand-written sequences for bounce, multi-key, enable and reset cases.
// Committed values go through a queue checked whenever valid pulses.
module tb_keypad_entry;

    localparam logic [11:0] STAR = 12'h400;
    localparam logic [11:0] HASH = 12'h800;

    typedef struct {
        logic [11:0] keys;
        logic [15:0] exp_hexx;
        logic [3:0]  exp_mask;
        logic        exp_full;
        logic        commit;
        logic [15:0] exp_value;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_valid = 0;
    logic [15:0] sb[$];
    vec_t vecs[15];

    keypad_entry_if bus();

    keypad_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] dig(input int d);
        return 12'(1 << d);
    endfunction

    function automatic vec_t mk(input logic [11:0] keys, input logic [15:0] h,
                                input logic [3:0] m, input logic f,
                                input logic c, input logic [15:0] val);
        vec_t r;
        r.keys = keys; r.exp_hexx = h; r.exp_mask = m; r.exp_full = f;
        r.commit = c; r.exp_value = val;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_keys(input logic [11:0] keys);
        bus.numbers  = keys[9:0];
        bus.asterisk = keys[10];
        bus.hash     = keys[11];
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [11:0] keys, input int hold, input int rel);
        set_keys(keys);
        step(hold);
        set_keys(12'd0);
        step(rel);
    endtask

    task automatic check_buf(input string tag, input logic [15:0] h, input logic [3:0] m, input logic f);
        check({tag, "_hexx"}, bus.hexx, h);
        check({tag, "_mask"}, bus.mask, m);
        check({tag, "_full"}, bus.full, f);
    endtask

    // Every valid pulse must match the oldest outstanding commit.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            n_valid++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL valid_unexpected: got pulse with value %0h, expected no pulse", bus.value);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (bus.value !== e) begin
                    n_fail++;
                    $display("FAIL commit_value: got %0h, expected %0h", bus.value, e);
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(dig(2), 16'h0002, 4'b0001, 1'b0, 1'b0, 16'h0);
        vecs[1]  = mk(HASH,   16'h0000, 4'b0000, 1'b0, 1'b1, 16'h0002);
        vecs[2]  = mk(dig(1), 16'h0001, 4'b0001, 1'b0, 1'b0, 16'h0);
        vecs[3]  = mk(dig(2), 16'h0012, 4'b0011, 1'b0, 1'b0, 16'h0);
        vecs[4]  = mk(dig(3), 16'h0123, 4'b0111, 1'b0, 1'b0, 16'h0);
        vecs[5]  = mk(dig(4), 16'h1234, 4'b1111, 1'b1, 1'b0, 16'h0);
        vecs[6]  = mk(dig(5), 16'h1234, 4'b1111, 1'b1, 1'b0, 16'h0);
        vecs[7]  = mk(HASH,   16'h0000, 4'b0000, 1'b0, 1'b1, 16'h1234);
        vecs[8]  = mk(HASH,   16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0);
        vecs[9]  = mk(dig(3), 16'h0003, 4'b0001, 1'b0, 1'b0, 16'h0);
        vecs[10] = mk(dig(8), 16'h0038, 4'b0011, 1'b0, 1'b0, 16'h0);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
        vecs[11] = mk(STAR,   16'h0003, 4'b0001, 1'b0, 1'b0, 16'h0);
`else
        vecs[11] = mk(STAR,   16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0);
`endif
        vecs[12] = mk(STAR,   16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0);
        vecs[13] = mk(dig(9), 16'h0009, 4'b0001, 1'b0, 1'b0, 16'h0);
        vecs[14] = mk(STAR,   16'h0000, 4'b0000, 1'b0, 1'b0, 16'h0);

        bus.en = 1'b1;
        set_keys(12'd0);
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        check_buf("reset", 16'h0000, 4'b0000, 1'b0);
        check("reset_value", bus.value, 16'h0);
        check("reset_valid", bus.valid, 1'b0);

        // Clean press/release table.
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].commit) sb.push_back(vecs[i].exp_value);
            press(vecs[i].keys, 4, 4);
            check_buf($sformatf("vec%0d", i), vecs[i].exp_hexx, vecs[i].exp_mask, vecs[i].exp_full);
        end
        check("value_after_table", bus.value, 16'h1234);

        // Bounce on press and release of digit 7: one digit only.
        set_keys(dig(7)); step(1);
        set_keys(12'd0);  step(1);
        set_keys(dig(7)); step(2);
        set_keys(12'd0);  step(1);
        set_keys(dig(7)); step(4);
        check_buf("bounce_accept", 16'h0007, 4'b0001, 1'b0);
        set_keys(12'd0);  step(1);
        set_keys(dig(7)); step(1);
        set_keys(12'd0);  step(5);
        check_buf("bounce_release", 16'h0007, 4'b0001, 1'b0);

        // Two digits together never count as a press.
        press(dig(3) | dig(8), 10, 4);
        check_buf("multikey", 16'h0007, 4'b0001, 1'b0);

        // Pattern change mid-debounce aborts the press.
        set_keys(dig(5)); step(2);
        set_keys(dig(6)); step(1);
        set_keys(12'd0);  step(4);
        check_buf("deb_abort", 16'h0007, 4'b0001, 1'b0);

        // en low: a held key does nothing.
        bus.en = 1'b0;
        set_keys(dig(4)); step(20);
        check_buf("en_low_held", 16'h0007, 4'b0001, 1'b0);
        set_keys(12'd0);  step(2);
        bus.en = 1'b1;    step(5);
        check_buf("en_low_after", 16'h0007, 4'b0001, 1'b0);

        // en low mid-debounce freezes the count rather than restarting it.
        set_keys(dig(4)); step(2);
        bus.en = 1'b0;    step(20);
        bus.en = 1'b1;    step(1);
        check("en_pause_third", bus.hexx, 16'h0007);
        step(1);
        check_buf("en_pause_fourth", 16'h0074, 4'b0011, 1'b0);
        set_keys(12'd0);  step(4);

        // Reset during DEB with buffer 0012; the held key is re-debounced.
        sb.push_back(16'h0074);
        press(HASH, 4, 4);
        check("commit_74_value", bus.value, 16'h0074);
        press(dig(1), 4, 4);
        press(dig(2), 4, 4);
        check_buf("pre_reset", 16'h0012, 4'b0011, 1'b0);
        set_keys(dig(5)); step(2);
        rst = 1'b1;       step(1);
        check_buf("mid_reset", 16'h0000, 4'b0000, 1'b0);
        check("mid_reset_value", bus.value, 16'h0);
        rst = 1'b0;       step(3);
        check("post_reset_third", bus.hexx, 16'h0000);
        step(1);
        check_buf("post_reset_fourth", 16'h0005, 4'b0001, 1'b0);
        set_keys(12'd0);  step(4);

        check("sb_drain", sb.size(), 0);
        check("valid_pulses", n_valid, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
